alu_cmd_queue: RTL and testbench
================================

# alu_cmd_queue

Command front-end for the 4-bit ALU. Accepts (a, b, op) commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. Issues one command at a time to the registered ALU and captures each ALU result. Presents the result plus its opcode downstream over a second valid/ready handshake.

## Interface

- DEPTH, default 4, FIFO entries; power of 2, ≥ 2.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  command present.
- in_ready  output  1  FIFO can accept a command.
- in_a  input  4  operand a.
- in_b  input  4  operand b.
- in_op  input  2  opcode: 00 add, 01 sub, 10 and, 11 or.
- alu_a  output  4  registered operand a to the ALU.
- alu_b  output  4  registered operand b to the ALU.
- alu_op  output  2  registered opcode to the ALU.
- alu_result  input  4  ALU registered result.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_result  output  4  captured ALU result.
- out_op  output  2  opcode that produced out_result.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.

## Operation

- Push: in_valid && in_ready at a rising edge writes {in_a, in_b, in_op} at the write pointer.
- in_ready = (count < DEPTH), from registered count only. It is not combinational on pop.
- Pop: reads the FIFO head. It happens only in states IDLE and HOLD (see below).
- Pointers wrap modulo DEPTH.
- count += push − pop. A simultaneous push and pop leaves count unchanged.
- No bypass. A command pushed into an empty FIFO is popped at the next edge at the earliest.
- One command is in flight at a time. State machine:
  - IDLE: if count ≠ 0, pop the head, load alu_a/alu_b/alu_op, go to DRIVE. Otherwise stay.
  - DRIVE: the ALU samples alu_* at the closing edge. Go to SAMPLE.
  - SAMPLE: alu_result is valid. At the closing edge:
    - out_result ← alu_result;
    - out_op ← alu_op;
    - out_valid ← 1;
    - go to HOLD.
  - HOLD: out_valid = 1, and out_result/out_op are held stable. On out_ready:
    - out_valid ← 0 at that edge;
    - if count ≠ 0, pop, reload alu_*, go to DRIVE;
    - else go to IDLE.
- alu_a/alu_b/alu_op hold their last issued value until the next pop. They never change during DRIVE or SAMPLE.
- Results are bit-identical to the ALU, truncated to 4 bits (add/sub wrap mod 16). This block performs no arithmetic.
- A push arriving while the FIFO is full (in_valid && !in_ready) is ignored. Upstream must hold the command.

## Timing

- Reset (rst_n low, asynchronous):
  - state = IDLE;
  - pointers and count = 0;
  - in_ready = 1;
  - alu_a/alu_b/alu_op = 0;
  - out_valid = 0, out_result = 0, out_op = 0.
  - FIFO contents are don't-care.
- Reset asserted mid-operation discards all queued and in-flight commands. A result arriving later on alu_result is not captured.
- Latency, empty queue: push at edge E0 → pop at E1 → ALU samples at E2 → out_valid high after E3.
- Throughput with out_ready held high: one result per 3 cycles (out_valid pulses after E3, E6, E9, …). Each out_valid pulse lasts one cycle.
- Backpressure: out_valid stays high, and out_result/out_op stay stable, until the out_ready edge. No command is issued to the ALU during HOLD without out_ready.
- Full boundary: with count = DEPTH, in_ready = 0 for the whole cycle, even if a pop occurs at the closing edge. in_ready returns to 1 the cycle after the pop.
- Empty boundary: in HOLD with count = 0 and out_ready = 1 → IDLE. No spurious issue occurs.
- The ALU's reset (active-high) is driven at system level from !rst_n.

## Test plan

- Single add: push a=3, b=5, op=00 at E0, out_ready=1 → out_valid after E3, out_result=8, out_op=00. alu_a=3, alu_b=5 from E1 onward.
- Wrap: push 9−12 (op=01) and 15+1 (op=00) back-to-back → results 13 then 0, in order, 3 cycles apart.
- Full/backpressure: out_ready=0, push 6 commands (a=i, b=1, op=11), DEPTH=4:
  - the first command pops immediately;
  - in_ready falls with count=4;
  - the 6th command is held by upstream;
  - out_result=1 (0|1) is held stable until out_ready=1.
- Drain: release out_ready=1 in the full case → 5 results, a=0..4 → 1, 1, 3, 3, 5. in_ready rises the cycle after the first HOLD pop. count ends at 0 and state at IDLE.
- Reset mid-flight: queue 3 commands, assert rst_n=0 during SAMPLE → immediately out_valid=0, count=0, alu_*=0, in_ready=1. After release, no result appears.
- Simultaneous push/pop: at count=2 in HOLD, push while out_ready=1 → count stays 2, new command is stored at the tail, order is preserved.

Source files
------------

// File: rtl/alu_cmd_queue_if.sv
// rtl/alu_cmd_queue_if.sv - handshake and ALU bus bundle for alu_cmd_queue
//
// Signal groups:
//   command in : in_valid, in_ready, in_a[3:0], in_b[3:0], in_op[1:0]
//   ALU side   : alu_a[3:0], alu_b[3:0], alu_op[1:0] (to ALU), alu_result[3:0] (from ALU)
//   result out : out_valid, out_ready, out_result[3:0], out_op[1:0]
//   status     : count[$clog2(DEPTH):0] FIFO occupancy
// Modports: slave is the queue's view, master is the surrounding system's view.

interface alu_cmd_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_a;
    logic [3:0]    in_b;
    logic [1:0]    in_op;
    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic [1:0]    alu_op;
    logic [3:0]    alu_result;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_result;
    logic [1:0]    out_op;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid, in_a, in_b, in_op, alu_result, out_ready,
        output in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_op, count
    );

    modport master (
        output in_valid, in_a, in_b, in_op, alu_result, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_op, count
    );
endinterface

// File: rtl/alu_cmd_queue.sv
// rtl/alu_cmd_queue.sv - command FIFO and issue sequencer in front of the registered 4-bit ALU
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_cmd_queue_if.slave - command input handshake, ALU operand/result
//           bus, result output handshake, FIFO occupancy
// Parameter DEPTH: FIFO entries, power of 2, >= 2.

module alu_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_cmd_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [9:0]    head;
    logic          push;
    logic          pop;

    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic [1:0]    alu_op;
    logic          out_valid;
    logic [3:0]    out_result;
    logic [1:0]    out_op;

    // in_ready looks only at the registered count, so a pop at the closing
    // edge of a full cycle does not open the door in the same cycle.
    assign bus.in_ready   = (count < CW'(DEPTH));
    assign push           = bus.in_valid && bus.in_ready;
    assign head           = mem[rd_ptr];

    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;
    assign bus.alu_op     = alu_op;
    assign bus.out_valid  = out_valid;
    assign bus.out_result = out_result;
    assign bus.out_op     = out_op;
    assign bus.count      = count;

    // Pop decisions use the registered count, so a command pushed into an
    // empty FIFO is never bypassed straight to the ALU.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE:  state_nxt = SAMPLE;
            SAMPLE: state_nxt = HOLD;
            HOLD: begin
                if (bus.out_ready) begin
                    if (count != '0) begin
                        pop       = 1'b1;
                        state_nxt = DRIVE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage is not reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_a, bus.in_b, bus.in_op};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_op     <= '0;
        end else begin
            state <= state_nxt;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                alu_a  <= head[9:6];
                alu_b  <= head[5:2];
                alu_op <= head[1:0];
            end

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // alu_op still names the in-flight command during SAMPLE.
            if (state == SAMPLE) begin
                out_result <= bus.alu_result;
                out_op     <= alu_op;
                out_valid  <= 1'b1;
            end else if (state == HOLD && bus.out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb/tb_alu_cmd_queue.sv - directed self-checking bench for alu_cmd_queue

module tb_alu_cmd_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_queue_if #(.DEPTH(4)) bus ();

    alu_cmd_queue #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Registered ALU, reset from !rst_n at system level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_result <= 4'd0;
        end else begin
            case (bus.alu_op)
                2'b00:   bus.alu_result <= bus.alu_a + bus.alu_b;
                2'b01:   bus.alu_result <= bus.alu_a - bus.alu_b;
                2'b10:   bus.alu_result <= bus.alu_a & bus.alu_b;
                default: bus.alu_result <= bus.alu_a | bus.alu_b;
            endcase
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int got_res[$];
    int got_op[$];
    int got_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
    endtask

    // Runs ncyc cycles logging every out_valid sample; drops in_valid once
    // the pending command has been accepted.
    task automatic collect(input int ncyc);
        bit pushed;
        got_res.delete();
        got_op.delete();
        got_cyc.delete();
        for (int c = 0; c < ncyc; c++) begin
            if (bus.out_valid) begin
                got_res.push_back(int'(bus.out_result));
                got_op.push_back(int'(bus.out_op));
                got_cyc.push_back(c);
            end
            pushed = bus.in_valid && bus.in_ready;
            step();
            if (pushed) bus.in_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp3[5];
        int exp5_res[3];
        int exp5_op[3];
        int seen;

        exp3     = '{1, 3, 3, 5, 5};
        exp5_res = '{3, 0, 15};
        exp5_op  = '{1, 2, 3};

        bus.in_valid  = 1'b0;
        bus.in_a      = 4'd0;
        bus.in_b      = 4'd0;
        bus.in_op     = 2'd0;
        bus.out_ready = 1'b0;

        // Reset state
        step();
        step();
        check("rst_in_ready",   bus.in_ready, 1);
        check("rst_count",      bus.count, 0);
        check("rst_out_valid",  bus.out_valid, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_out_op",     bus.out_op, 0);
        check("rst_alu_a",      bus.alu_a, 0);
        check("rst_alu_op",     bus.alu_op, 0);
        rst_n = 1'b1;
        step();

        // Single add 3+5
        bus.out_ready = 1'b1;
        send(4'd3, 4'd5, 2'b00);
        step();                                   // E0 push
        bus.in_valid = 1'b0;
        check("t1_count_e0", bus.count, 1);
        check("t1_valid_e0", bus.out_valid, 0);
        step();                                   // E1 pop
        check("t1_alu_a_e1", bus.alu_a, 3);
        check("t1_alu_b_e1", bus.alu_b, 5);
        check("t1_count_e1", bus.count, 0);
        step();                                   // E2
        check("t1_valid_e2", bus.out_valid, 0);
        check("t1_alu_a_e2", bus.alu_a, 3);
        step();                                   // E3
        check("t1_valid_e3", bus.out_valid, 1);
        check("t1_result",   bus.out_result, 8);
        check("t1_op",       bus.out_op, 0);
        step();                                   // E4
        check("t1_valid_e4", bus.out_valid, 0);

        // Wrap: 9-12 then 15+1
        send(4'd9, 4'd12, 2'b01);
        step();                                   // E0
        send(4'd15, 4'd1, 2'b00);
        step();                                   // E1 push + pop
        bus.in_valid = 1'b0;
        check("t2_count_e1", bus.count, 1);
        step();                                   // E2
        check("t2_valid_e2", bus.out_valid, 0);
        step();                                   // E3
        check("t2_valid_e3", bus.out_valid, 1);
        check("t2_res0",     bus.out_result, 13);
        check("t2_op0",      bus.out_op, 1);
        step();
        check("t2_valid_e4", bus.out_valid, 0);
        step();
        check("t2_valid_e5", bus.out_valid, 0);
        step();                                   // E6
        check("t2_valid_e6", bus.out_valid, 1);
        check("t2_res1",     bus.out_result, 0);
        check("t2_op1",      bus.out_op, 0);
        step();
        check("t2_valid_e7", bus.out_valid, 0);
        check("t2_count_e7", bus.count, 0);

        // Full / backpressure
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                check("t3_first_pop_op", bus.alu_op, 3);
                check("t3_first_pop_a",  bus.alu_a, 0);
            end
            send(4'(i), 4'd1, 2'b11);
            check("t3_in_ready_fill", bus.in_ready, 1);
            step();
        end
        check("t3_count_full", bus.count, 4);
        check("t3_in_ready_0", bus.in_ready, 0);
        check("t3_valid_hold", bus.out_valid, 1);
        check("t3_res_hold",   bus.out_result, 1);
        check("t3_op_hold",    bus.out_op, 3);
        send(4'd5, 4'd1, 2'b11);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_bp_in_ready", bus.in_ready, 0);
            check("t3_bp_count",    bus.count, 4);
            check("t3_bp_valid",    bus.out_valid, 1);
            check("t3_bp_result",   bus.out_result, 1);
            check("t3_bp_alu_a",    bus.alu_a, 0);
        end

        // Drain
        bus.out_ready = 1'b1;
        step();                                   // HOLD pop, in_ready still 0 at this edge
        check("t3_in_ready_rise", bus.in_ready, 1);
        check("t3_count_after_pop", bus.count, 3);
        check("t3_valid_after_pop", bus.out_valid, 0);
        check("t3_alu_a_c1", bus.alu_a, 1);
        collect(20);
        check("t3_n_results", got_res.size(), 5);
        for (int k = 0; k < 5 && k < got_res.size(); k++) begin
            check("t3_drain_res", got_res[k], exp3[k]);
            check("t3_drain_op",  got_op[k], 3);
            if (k > 0) check("t3_spacing", got_cyc[k] - got_cyc[k-1], 3);
        end
        check("t3_count_end",    bus.count, 0);
        check("t3_in_ready_end", bus.in_ready, 1);
        check("t3_valid_end",    bus.out_valid, 0);

        // Reset mid-flight
        bus.out_ready = 1'b0;
        send(4'd7, 4'd2, 2'b00);
        step();
        send(4'd8, 4'd3, 2'b01);
        step();
        send(4'd9, 4'd4, 2'b10);
        step();                                   // now in SAMPLE
        bus.in_valid = 1'b0;
        check("t4_count_pre", bus.count, 2);
        rst_n = 1'b0;
        #1;
        check("t4_valid",    bus.out_valid, 0);
        check("t4_count",    bus.count, 0);
        check("t4_alu_a",    bus.alu_a, 0);
        check("t4_alu_b",    bus.alu_b, 0);
        check("t4_alu_op",   bus.alu_op, 0);
        check("t4_in_ready", bus.in_ready, 1);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.out_valid) seen++;
        end
        check("t4_no_result", seen, 0);
        check("t4_count_end", bus.count, 0);

        // Simultaneous push/pop in HOLD at count=2
        bus.out_ready = 1'b0;
        send(4'd1, 4'd2, 2'b00);
        step();
        send(4'd6, 4'd3, 2'b01);
        step();
        send(4'd10, 4'd5, 2'b10);
        step();
        bus.in_valid = 1'b0;
        step();                                   // HOLD
        check("t5_valid_hold", bus.out_valid, 1);
        check("t5_res_hold",   bus.out_result, 3);
        check("t5_count_hold", bus.count, 2);
        bus.out_ready = 1'b1;
        send(4'd12, 4'd3, 2'b11);
        step();                                   // push + pop
        bus.in_valid = 1'b0;
        check("t5_count_same", bus.count, 2);
        check("t5_valid_drop", bus.out_valid, 0);
        check("t5_alu_a",      bus.alu_a, 6);
        collect(16);
        check("t5_n_results", got_res.size(), 3);
        for (int k = 0; k < 3 && k < got_res.size(); k++) begin
            check("t5_res", got_res[k], exp5_res[k]);
            check("t5_op",  got_op[k], exp5_op[k]);
        end
        check("t5_count_end", bus.count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
